// File: rtl/prng_pkg.sv
// Shared types and pure helpers for the bounded-range PRNG.
// Helpers work on a 64-bit word; callers zero-extend narrower values.
package prng_pkg;

  localparam int LFSR_MAX_W = 64;

  typedef logic [LFSR_MAX_W-1:0] lfsr_word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    RESP = 2'd2
  } fsm_state_t;

  // One Galois shift. Zero-extension means the shift brings in zeros above LEN,
  // so the same function serves every LEN up to LFSR_MAX_W.
  function automatic lfsr_word_t lfsr_step(input lfsr_word_t s, input lfsr_word_t taps);
    return (s >> 1) ^ (s[0] ? taps : '0);
  endfunction

  // Smallest all-ones pattern covering x (x=0 gives 0).
  function automatic lfsr_word_t smear_mask(input lfsr_word_t x);
    lfsr_word_t m;
    m = x;
    for (int i = 0; i < 6; i++) begin
      m = m | (m >> (1 << i));
    end
    return m;
  endfunction

endpackage

// File: rtl/prng_range_gen_if.sv
// Request/response bus of the range generator. The consumer is the master.
interface prng_range_gen_if #(
  parameter int LEN = 16
);

  logic           req_valid;
  logic           req_ready;
  logic [LEN-1:0] req_bound;
  logic           resp_valid;
  logic           resp_ready;
  logic [LEN-1:0] resp_value;

  modport master (
    output req_valid,
    output req_bound,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_value
  );

  modport slave (
    input  req_valid,
    input  req_bound,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_value
  );

endinterface

// File: rtl/prng_range_gen_lfsr_core.sv
// Free-running Galois LFSR: STEPS unrolled shifts per enabled edge,
// seed load with priority, and a guard that never lets the state reach zero.
module lfsr_core
  import prng_pkg::*;
#(
  parameter int             LEN   = 16,
  parameter logic [LEN-1:0] TAPS  = LEN'(16'hB400),
  parameter int             STEPS = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [LEN-1:0] seed,
  input  logic           seed_load,
  output logic [LEN-1:0] state
);

  logic [LEN-1:0] state_reg;
  logic [LEN-1:0] state_next;
  logic [LEN-1:0] seed_safe;
  logic [LEN-1:0] chain [STEPS+1];

  assign seed_safe = (seed == '0) ? LEN'(1) : seed;
  assign chain[0]  = state_reg;

  genvar gi;
  generate
    for (gi = 0; gi < STEPS; gi++) begin : g_step
      assign chain[gi+1] = LEN'(lfsr_step(LFSR_MAX_W'(chain[gi]), LFSR_MAX_W'(TAPS)));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    if (seed_load) begin
      state_next = seed_safe;
    end else if (en) begin
      state_next = chain[STEPS];
    end
    // A zero state would lock the register forever.
    if (state_next == '0) begin
      state_next = LEN'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= seed_safe;
    end else begin
      state_reg <= state_next;
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/prng_range_gen.sv
// Uniform draw in [0, bound) by masked rejection sampling on the LFSR state,
// with a bounded retry count and a subtract-bound fallback.
module prng_range_gen
  import prng_pkg::*;
#(
  parameter int             LEN     = 16,
  parameter logic [LEN-1:0] TAPS    = LEN'(16'hB400),
  parameter int             STEPS   = 1,
  parameter int             MAX_TRY = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [LEN-1:0]   seed,
  input  logic             seed_load,
  prng_range_gen_if.slave  bus,
  output logic [LEN-1:0]   state
);

  localparam int               TRY_W    = $clog2(MAX_TRY + 1);
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRY - 1);

  fsm_state_t       fsm_reg, fsm_next;
  logic [LEN-1:0]   bound_reg, bound_next;
  logic [LEN-1:0]   mask_reg, mask_next;
  logic [LEN-1:0]   resp_value_reg, resp_value_next;
  logic [TRY_W-1:0] try_cnt_reg, try_cnt_next;
  logic [LEN-1:0]   bound_m1;
  logic [LEN-1:0]   cand;

  lfsr_core #(
    .LEN   (LEN),
    .TAPS  (TAPS),
    .STEPS (STEPS)
  ) u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .seed      (seed),
    .seed_load (seed_load),
    .state     (state)
  );

  // bound 0 wraps to all-ones, which is exactly the full-range mask.
  assign bound_m1 = bus.req_bound - LEN'(1);
  assign cand     = state & mask_reg;

  always_comb begin
    fsm_next        = fsm_reg;
    bound_next      = bound_reg;
    mask_next       = mask_reg;
    try_cnt_next    = try_cnt_reg;
    resp_value_next = resp_value_reg;
    case (fsm_reg)
      IDLE: begin
        if (bus.req_valid) begin
          bound_next   = bus.req_bound;
          mask_next    = LEN'(smear_mask(LFSR_MAX_W'(bound_m1)));
          try_cnt_next = '0;
          fsm_next     = DRAW;
        end
      end
      DRAW: begin
        if (en) begin
          if (bound_reg == '0 || cand < bound_reg) begin
            resp_value_next = cand;
            fsm_next        = RESP;
          end else if (try_cnt_reg == TRY_LAST) begin
            // mask < 2*bound, so one subtraction lands inside the range.
            resp_value_next = cand - bound_reg;
            fsm_next        = RESP;
          end else begin
            try_cnt_next = try_cnt_reg + TRY_W'(1);
          end
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          fsm_next = IDLE;
        end
      end
      default: begin
        fsm_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm_reg        <= IDLE;
      bound_reg      <= '0;
      mask_reg       <= '0;
      try_cnt_reg    <= '0;
      resp_value_reg <= '0;
    end else begin
      fsm_reg        <= fsm_next;
      bound_reg      <= bound_next;
      mask_reg       <= mask_next;
      try_cnt_reg    <= try_cnt_next;
      resp_value_reg <= resp_value_next;
    end
  end

  assign bus.req_ready  = (fsm_reg == IDLE);
  assign bus.resp_valid = (fsm_reg == RESP);
  assign bus.resp_value = resp_value_reg;

endmodule

// File: doc/prng_range_gen.md
Name: prng_range_gen

Overview:
- Parametrised successor to the single-step Galois LFSR.
- Free-running Galois LFSR with:
  - configurable width, taps and steps per clock;
  - run enable, runtime reseed, and a zero-state lock-up guard;
  - a request/response front end that returns a uniform value in [0, bound).
- Rejection sampling is bounded by a retry limit, with a deterministic fallback.
- Consumers include alien fire selection, column choice and the UFO timer.

Parameters:
- LEN, 16, LFSR and output width in bits (≥ 4).
- TAPS, 16'hB400, Galois tap mask XORed into the right-shifted state when the shifted-out bit is 1.
- STEPS, 1, LFSR shifts applied per enabled clock (1..LEN, unrolled combinationally).
- MAX_TRY, 8, draw attempts before fallback (≥ 1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active low
- en  in  1  LFSR advance enable
- seed  in  LEN  seed value, loaded at reset and on seed_load
- seed_load  in  1  load seed on the next edge
- req_valid  in  1  draw request
- req_ready  out  1  request accepted when high together with req_valid
- req_bound  in  LEN  exclusive upper bound; 0 means full range
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes the result
- resp_value  out  LEN  drawn value
- state  out  LEN  raw LFSR state, for debug and cheap uses

Behaviour:
- Reset: sampled on a clk edge while rst=0.
  - state <= seed, or 1 if seed==0.
  - FSM goes to IDLE.
  - Outputs: req_ready=1, resp_valid=0, resp_value=0.
  - Reset mid-draw or mid-response aborts that transaction with no response.
- Step function, one shift: s' = {0, s[LEN-1:1]} ^ (s[0] ? TAPS : 0). STEPS shifts are applied per enabled edge.
- State priority each edge:
  1. seed_load: state <= seed, with 0 replaced by 1.
  2. else en: state <= step^STEPS(state).
  3. else hold.
  - Lock-up guard: if the next state would be 0, load 1 instead.
- Mask: mask = (2^k)-1 with minimal k such that mask ≥ bound-1.
  - bound 0 or 1 gives mask 0 for bound 1 and all-ones for bound 0.
  - The mask is computed combinationally from bound-1, e.g. OR-smear, and registered with bound on accept.
- FSM IDLE:
  - req_ready=1.
  - On req_valid: latch bound and mask, clear try_cnt, go to DRAW.
- FSM DRAW:
  - req_ready=0.
  - Only evaluates on cycles with en=1; while en=0 it waits, the state is frozen, and try_cnt is unchanged.
  - cand = state & mask, using the state present this cycle, i.e. before this edge's step.
  - bound==0, or cand < bound: resp_value <= cand, go to RESP.
  - else if try_cnt == MAX_TRY-1: resp_value <= cand - bound (always < bound because mask < 2*bound), go to RESP.
  - else try_cnt++.
- FSM RESP:
  - resp_valid=1; resp_value is stable until resp_ready.
  - On resp_ready: resp_valid <= 0, go to IDLE.
  - A new request is accepted at the earliest on the cycle after returning to IDLE.
- Latency: accept edge → resp_valid high after 1 + attempts enabled cycles. The minimum is 2 edges.
- seed_load during DRAW: the current cycle's attempt uses the pre-load state, and later attempts use the seeded sequence.
- try_cnt width: $clog2(MAX_TRY+1).

Decomposition:
- Package prng_pkg contains:
  - FSM enum (IDLE, DRAW, RESP);
  - function lfsr_step(s, taps), with a width-parametrised form;
  - function smear_mask.
- Sub-module lfsr_core (LEN, TAPS, STEPS) owns the state register, seed load, enable and lock-up guard.
- prng_range_gen instantiates lfsr_core and holds the FSM.

Test Plan:
1. Sequence check: seed=1, reset, en=1, no requests → state reads 0001, B400, 5A00, 2D00, …, 002D, B416 on successive edges.
2. Lock-up guard: seed=0 at reset → state=0001. Also seed_load with seed=0 while en=1 → state=0001 next edge.
3. Direct accept: seed=03FF, req_bound=0201 asserted the first cycle after reset, en=1, resp_ready=1 → accept with state B5FF, resp_value=01FF, resp_valid 2 edges after accept.
4. Retry then accept: seed=03FF, req_bound=0101 → first candidate 01FF is rejected, second candidate from EEFF is accepted → resp_value=00FF after 3 edges.
5. Fallback: MAX_TRY=1 build, same stimulus as scenario 4 → resp_value=01FF-0101=00FE after 2 edges.
6. Handshake and reset:
   - Hold resp_ready=0 for 5 cycles → resp_valid and resp_value stable, and req_ready=0.
   - Pulse rst low during DRAW → next cycle IDLE, resp_valid=0, state=seed.
   - req_bound=1 → resp_value=0.
   - en=0 during DRAW → no progress until en returns.
